// File: rtl/rsnn_pkg.sv
// Shared types and constants for the RSNN spike-path blocks.
package rsnn_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [7:0] SAT_MAX  = 8'hFF;
  localparam logic [7:0] ISI_NONE = 8'hFF;

endpackage

// File: rtl/rsnn_sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module rsnn_sat_counter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {DATA_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a 1-bit spike train into a per-window spike count and minimum
// inter-spike interval, delivered on a valid/ready output with overrun flag.
module spike_rate_decoder
  import rsnn_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic              spike_in,
  input  logic [DATA_W-1:0] window_len,
  output logic [DATA_W-1:0] rate_out,
  output logic [DATA_W-1:0] min_isi_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  state_t            state_q, state_d;
  logic [DATA_W:0]   winLeft_q, winLeft_d;
  logic              seen_q, seen_d;
  logic [DATA_W-1:0] minIsi_q, minIsi_d;
  logic [DATA_W-1:0] rate_q, rate_d;
  logic [DATA_W-1:0] minOut_q, minOut_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  logic [DATA_W-1:0] spkCnt;
  logic [DATA_W-1:0] isiCnt;
  logic [DATA_W:0]   lenEff;
  logic [DATA_W:0]   curLeft;
  logic              sample;
  logic              sampleSpike;
  logic              winEnd;
  logic [DATA_W-1:0] spkFinal;
  logic [DATA_W-1:0] isiCand;
  logic [DATA_W-1:0] minIsiNew;

  // winLeft_q == 0 marks "next sample starts a window", so window_len is
  // only consulted on that first sample.
  assign sample      = enable & ~restart;
  assign sampleSpike = sample & spike_in;
  assign lenEff      = (window_len == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, window_len};
  assign curLeft     = (winLeft_q == '0) ? lenEff : winLeft_q;
  assign winEnd      = sample && (curLeft == {{DATA_W{1'b0}}, 1'b1});

  assign spkFinal  = (spkCnt == SAT_MAX) ? SAT_MAX : spkCnt + {{(DATA_W-1){1'b0}}, spike_in};
  assign isiCand   = (isiCnt == SAT_MAX) ? SAT_MAX : isiCnt + 1'b1;
  assign minIsiNew = (sampleSpike && seen_q && (isiCand < minIsi_q)) ? isiCand : minIsi_q;

  rsnn_sat_counter #(.DATA_W(DATA_W)) u_spk_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sampleSpike),
    .clr   (restart | winEnd),
    .q     (spkCnt)
  );

  rsnn_sat_counter #(.DATA_W(DATA_W)) u_isi_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sample & ~spike_in),
    .clr   (restart | winEnd | sampleSpike),
    .q     (isiCnt)
  );

  always_comb begin
    state_d   = state_q;
    winLeft_d = winLeft_q;
    seen_d    = seen_q;
    minIsi_d  = minIsi_q;
    rate_d    = rate_q;
    minOut_d  = minOut_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if ((state_q == IDLE) && sample) begin
      state_d = COUNT;
    end

    if (restart) begin
      winLeft_d = '0;
      seen_d    = 1'b0;
      minIsi_d  = ISI_NONE;
    end else if (sample) begin
      winLeft_d = curLeft - 1'b1;
      if (winEnd) begin
        seen_d   = 1'b0;
        minIsi_d = ISI_NONE;
      end else begin
        seen_d   = seen_q | spike_in;
        minIsi_d = minIsiNew;
      end
    end

    // A new result replaces the held one; losing an unaccepted result is sticky.
    if (winEnd) begin
      rate_d   = spkFinal;
      minOut_d = minIsiNew;
      valid_d  = 1'b1;
      if (valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      winLeft_q <= '0;
      seen_q    <= 1'b0;
      minIsi_q  <= ISI_NONE;
      rate_q    <= '0;
      minOut_q  <= ISI_NONE;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winLeft_q <= winLeft_d;
      seen_q    <= seen_d;
      minIsi_q  <= minIsi_d;
      rate_q    <= rate_d;
      minOut_q  <= minOut_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rate_out    = rate_q;
  assign min_isi_out = minOut_q;
  assign out_valid   = valid_q;
  assign overrun     = overrun_q;

endmodule
